// File: rtl/bcd.sv
// bcd: 8-bit unsigned binary to 3-digit packed BCD (hundreds, tens, ones).
// Two register stages with the double-dabble conversion unrolled between
// them. Accepts one sample per clock; a sample presented at edge N shows up
// on H/T/O with out_valid=1 after edge N+1.
//
// Handshake: valid-only, no backpressure. in_valid qualifies Input on the
// rising edge it is sampled; out_valid is a one-cycle pulse marking the cycle
// in which H/T/O carry a new result. Results leave in arrival order.
module bcd #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] Input,
    output logic             out_valid,
    output logic [3:0]       H,
    output logic [3:0]       T,
    output logic [3:0]       O
);

    // Stage-1 registers
    logic [7:0]  r_data;
    logic        r_v1;

    // Stage-2 (output) registers
    logic [3:0]  r_h;
    logic [3:0]  r_t;
    logic [3:0]  r_o;
    logic        r_ov;

    // Conversion result between the stages
    logic [11:0] w_bcd;

    // Stage 1: capture the input sample; data holds when nothing is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= 8'd0;
            r_v1   <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_data <= Input;
            end
        end
    end

    // Double-dabble: the 12-bit BCD part of the scratch register is kept
    // separately and each shift pulls in the next data bit, MSB first.
    always_comb begin
        w_bcd = 12'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_bcd[3:0] >= 4'd5) begin
                w_bcd[3:0] = w_bcd[3:0] + 4'd3;
            end
            if (w_bcd[7:4] >= 4'd5) begin
                w_bcd[7:4] = w_bcd[7:4] + 4'd3;
            end
            if (w_bcd[11:8] >= 4'd5) begin
                w_bcd[11:8] = w_bcd[11:8] + 4'd3;
            end
            w_bcd = {w_bcd[10:0], r_data[7-i]};
        end
    end

    // Stage 2: load digits for a valid stage-1 sample, otherwise hold them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h  <= 4'd0;
            r_t  <= 4'd0;
            r_o  <= 4'd0;
            r_ov <= 1'b0;
        end else begin
            r_ov <= r_v1;
            if (r_v1) begin
                r_h <= w_bcd[11:8];
                r_t <= w_bcd[7:4];
                r_o <= w_bcd[3:0];
            end
        end
    end

    assign out_valid = r_ov;
    assign H         = r_h;
    assign T         = r_t;
    assign O         = r_o;

endmodule

// File: tb/tb_bcd.sv
// tb_bcd: self-checking bench for the bcd converter. Expected digits come
// from plain decimal arithmetic on the input value.
module tb_bcd;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] Input;
    logic       out_valid;
    logic [3:0] H;
    logic [3:0] T;
    logic [3:0] O;

    int n_checks;
    int n_pass;

    logic [11:0] exp_q[$];

    bcd #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .Input     (Input),
        .out_valid (out_valid),
        .H         (H),
        .T         (T),
        .O         (O)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: decimal digits of v packed as {hundreds, tens, ones}
    function automatic logic [11:0] ref_digits(input int v);
        int h;
        int t;
        int o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        return {h[3:0], t[3:0], o[3:0]};
    endfunction

    // driver: wait for the falling edge, then apply inputs for the next rise
    task automatic drive(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        Input    = d;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 8'hFF);
            n_checks++;
            if ({out_valid, H, T, O} !== 13'd0)
                $display("FAIL reset_hold cycle %0d: got ov=%b H=%0d T=%0d O=%0d, want ov=0 0,0,0",
                         i, out_valid, H, T, O);
            else
                n_pass++;
        end
        // first valid sample after reset release: result two edges later
        drive(1'b0, 1'b1, 8'd42);
        n_checks++;
        if ({out_valid, H, T, O} !== 13'd0)
            $display("FAIL reset_release_edge1: got ov=%b H=%0d T=%0d O=%0d, want ov=0 0,0,0",
                     out_valid, H, T, O);
        else
            n_pass++;
        drive(1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({out_valid, H, T, O} !== {1'b0, 12'h000})
            $display("FAIL reset_release_edge2: got ov=%b H=%0d T=%0d O=%0d, want ov=0 0,0,0",
                     out_valid, H, T, O);
        else
            n_pass++;
        drive(1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({out_valid, H, T, O} !== {1'b1, 12'h042})
            $display("FAIL reset_first_result: got ov=%b H=%0d T=%0d O=%0d, want ov=1 0,4,2",
                     out_valid, H, T, O);
        else
            n_pass++;
    endtask

    task automatic test_directed;
        logic [7:0]  vals[11];
        logic [11:0] exps[11];
        logic [11:0] e;
        vals = '{8'h00, 8'h01, 8'h05, 8'h15, 8'h35, 8'h73,
                 8'hB7, 8'hF1, 8'hB9, 8'hF5, 8'hFF};
        exps = '{12'h000, 12'h001, 12'h005, 12'h021, 12'h053, 12'h115,
                 12'h183, 12'h241, 12'h185, 12'h245, 12'h255};
        exp_q.delete();
        for (int i = 0; i < 15; i++) begin
            if (i < 11) drive(1'b0, 1'b1, vals[i]);
            else        drive(1'b0, 1'b0, 8'h00);
            if (i < 11) exp_q.push_back(exps[i]);
            if (i >= 2 && i < 13) begin
                e = exps[i-2];
                n_checks++;
                if (out_valid !== 1'b1 || {H, T, O} !== e)
                    $display("FAIL directed 0x%02h: got ov=%b %0d,%0d,%0d, want ov=1 %0d,%0d,%0d",
                             vals[i-2], out_valid, H, T, O, e[11:8], e[7:4], e[3:0]);
                else
                    n_pass++;
            end
        end
        exp_q.delete();
    endtask

    task automatic test_throughput;
        int          run;
        int          max_run;
        int          bad;
        int          seen;
        logic [11:0] e;
        run = 0; max_run = 0; bad = 0; seen = 0;
        exp_q.delete();
        for (int i = 0; i < 262; i++) begin
            if (i < 256) drive(1'b0, 1'b1, 8'(i));
            else         drive(1'b0, 1'b0, 8'h00);
            if (out_valid) begin
                run++;
                seen++;
                if (run > max_run) max_run = run;
                if (exp_q.size() == 0) begin
                    bad++;
                end else begin
                    e = exp_q.pop_front();
                    if ({H, T, O} !== e) begin
                        bad++;
                        if (bad <= 5)
                            $display("FAIL stream_data #%0d: got %0d,%0d,%0d, want %0d,%0d,%0d",
                                     seen - 1, H, T, O, e[11:8], e[7:4], e[3:0]);
                    end
                end
            end else begin
                run = 0;
            end
            if (i < 256) exp_q.push_back(ref_digits(i));
        end
        n_checks++;
        if (max_run !== 256)
            $display("FAIL stream_run: got longest out_valid run %0d, want 256", max_run);
        else
            n_pass++;
        n_checks++;
        if (bad !== 0 || exp_q.size() !== 0)
            $display("FAIL stream_order: got %0d bad results, %0d undelivered, want 0 and 0",
                     bad, exp_q.size());
        else
            n_pass++;
    endtask

    task automatic test_hold;
        int pulses;
        int held_bad;
        pulses = 0; held_bad = 0;
        drive(1'b0, 1'b1, 8'h73);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 8'($urandom_range(0, 255)));
            if (out_valid) pulses++;
            if (i >= 1 && {H, T, O} !== 12'h115) begin
                held_bad++;
                $display("FAIL hold_digits cycle %0d: got %0d,%0d,%0d, want 1,1,5", i, H, T, O);
            end
        end
        n_checks++;
        if (pulses !== 1)
            $display("FAIL hold_pulses: got %0d out_valid pulses, want 1", pulses);
        else
            n_pass++;
        n_checks++;
        if (held_bad === 0) n_pass++;
    endtask

    task automatic test_reset_midstream;
        int bad;
        bad = 0;
        drive(1'b0, 1'b1, 8'hFF);
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 8'($urandom_range(0, 255)));
            if ({out_valid, H, T, O} !== 13'd0) begin
                bad++;
                $display("FAIL midreset_quiet cycle %0d: got ov=%b %0d,%0d,%0d, want ov=0 0,0,0",
                         i, out_valid, H, T, O);
            end
        end
        n_checks++;
        if (bad === 0) n_pass++;
        drive(1'b0, 1'b1, 8'h15);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({out_valid, H, T, O} !== {1'b1, 12'h021})
            $display("FAIL midreset_next: got ov=%b %0d,%0d,%0d, want ov=1 0,2,1",
                     out_valid, H, T, O);
        else
            n_pass++;
    endtask

    task automatic test_random;
        int          bad;
        int          extra;
        logic        v;
        logic [7:0]  d;
        logic [11:0] e;
        bad = 0; extra = 0;
        exp_q.delete();
        for (int i = 0; i < 306; i++) begin
            v = (i < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
            d = 8'($urandom_range(0, 255));
            drive(1'b0, v, d);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    e = exp_q.pop_front();
                    if ({H, T, O} !== e) begin
                        bad++;
                        if (bad <= 5)
                            $display("FAIL random_data: got %0d,%0d,%0d, want %0d,%0d,%0d",
                                     H, T, O, e[11:8], e[7:4], e[3:0]);
                    end
                end
            end
            if (v) exp_q.push_back(ref_digits(int'(d)));
        end
        n_checks++;
        if (bad !== 0 || extra !== 0 || exp_q.size() !== 0)
            $display("FAIL random_stream: got %0d bad, %0d extra, %0d missing, want 0,0,0",
                     bad, extra, exp_q.size());
        else
            n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        in_valid = 1'b1;
        Input    = 8'hFF;
        test_reset();
        test_directed();
        test_throughput();
        test_hold();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd.md
Name: bcd

Overview:
- Clocked 8-bit unsigned binary to 3-digit packed BCD converter (hundreds, tens, ones).
- Used as the display/decimal-formatting stage after the combinational multiplier datapath.
- Fully pipelined: accepts one sample per clock, with a fixed latency of 2 cycles.
- Conversion uses the shift-and-add-3 (double-dabble) algorithm, unrolled combinationally between two register stages.

Parameters:
- WIDTH, 8, binary input width. Fixed at 8; the digit count of 3 is derived from it. Other values are unsupported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies Input on this clock edge.
- Input  input  8  unsigned binary value, 0..255.
- out_valid  output  1  high for one cycle per accepted sample when H/T/O carry its result.
- H  output  4  hundreds digit, 0..2.
- T  output  4  tens digit, 0..9.
- O  output  4  ones digit, 0..9.

Behaviour:
- Reset, sampled at a rising edge while rst=1:
  - Input register and all valid flags clear to 0.
  - Outputs become H=T=O=4'd0 and out_valid=0.
  - Any in-flight sample is discarded; reset has priority over in_valid.
- Stage 1: on an edge with in_valid=1, register Input and set the stage-1 valid flag. If in_valid=0, the stage-1 valid flag clears and the data register holds its value.
- Combinational conversion between stages (double-dabble):
  - 20-bit scratch = {12'b0, data}.
  - Repeat 8 times: for each BCD nibble (bits [11:8], [15:12], [19:16]), add 3 if the nibble is >= 5; then shift the whole scratch left by 1.
  - Result: H=[19:16], T=[15:12], O=[11:8].
  - Equivalent to H = v/100, T = (v/10)%10, O = v%10.
- Stage 2: on the edge after a valid stage-1 sample, load H/T/O and pulse out_valid=1. Otherwise out_valid=0 and H/T/O hold their last value.
- Latency and throughput:
  - Input presented at edge N appears on H/T/O, with out_valid=1, after edge N+1.
  - Back-to-back samples produce back-to-back results in order, with no bubbles.
- Range limits:
  - Every 8-bit value is valid; there is no overflow.
  - H never exceeds 2; T and O never exceed 9.
  - Digits are never in the range 10..15.
- Outputs are driven only from registers; there is no combinational path from Input to H/T/O.
- Reset deasserting mid-stream: the first result appears 2 edges after the first in_valid=1 sampled with rst=0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and Input=8'hFF -> H/T/O=0 and out_valid=0 throughout. After rst drops, the first result appears 2 edges later.
- Directed values, one per cycle, in_valid=1, each checked 2 edges later:
  - 0x00 -> 0,0,0
  - 0x01 -> 0,0,1
  - 0x05 -> 0,0,5
  - 0x15 (21) -> 0,2,1
  - 0x35 (53) -> 0,5,3
  - 0x73 (115) -> 1,1,5
- More directed values, same checking:
  - 0xB7 (183) -> 1,8,3
  - 0xF1 (241) -> 2,4,1
  - 0xB9 (185) -> 1,8,5
  - 0xF5 (245) -> 2,4,5
  - 0xFF (255) -> 2,5,5
- Throughput: stream Input=0..255 back-to-back with in_valid=1 -> out_valid is high for 256 consecutive cycles, and the results match a v/100, (v/10)%10, v%10 model in order.
- Hold: send 0x73, then drop in_valid for 5 cycles while Input toggles -> out_valid pulses once, and H/T/O stay at 1,1,5.
- Reset mid-stream: assert rst for one edge while 0xFF is in stage 1 -> no out_valid for that sample; outputs read 0,0,0 until the next valid sample.
